// File: rtl/uart_to_bram_if.sv
// BRAM port-A write bus between the UART loader and the memory.
// master: bram_addr, bram_din, bram_we out; slave: same signals in.
interface uart_to_bram_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] bram_addr;
  logic [DATA_WIDTH-1:0] bram_din;
  logic                  bram_we;

  modport master (
    output bram_addr,
    output bram_din,
    output bram_we
  );

  modport slave (
    input bram_addr,
    input bram_din,
    input bram_we
  );
endinterface

// File: rtl/uart_to_bram.sv
// 8N1 UART receiver packing bytes LSB-first into words written to BRAM.
// Ports: clk, reset, uart_rx, clear, bram (write bus), word_count, full, frame_err.
module uart_to_bram #(
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_WIDTH   = 32,
  parameter int CLK_FREQ     = 100_000_000,
  parameter int BAUD_RATE    = 9600,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                uart_rx,
  input  logic                clear,
  uart_to_bram_if.master      bram,
  output logic [ADDR_WIDTH:0] word_count,
  output logic                full,
  output logic                frame_err
);

  localparam int CPB  = CLK_FREQ / BAUD_RATE;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB + 1);
  localparam int BPW  = DATA_WIDTH / 8;
  localparam int IW   = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int TO   = TIMEOUT_BITS * CPB;
  localparam int TW   = $clog2(TO + 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      sh_q, sh_d;
  logic            rx_m, rx_s;
  logic            byte_ok, stop_bad;

  logic [IW-1:0]         byte_idx;
  logic [DATA_WIDTH-1:0] word_q, word_nx;
  logic [TW-1:0]         to_cnt;
  logic                  last, idle_part;

  // Sync flops reset high so a line idling low after reset
  // still needs rx_s to fall before a start is seen.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= uart_rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    bit_d    = bit_q;
    sh_d     = sh_q;
    byte_ok  = 1'b0;
    stop_bad = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (cnt_q == CW'(HALF - 1)) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == CW'(CPB - 1)) begin
          cnt_d = '0;
          sh_d  = {rx_s, sh_q[7:1]};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == CW'(CPB - 1)) begin
          cnt_d    = '0;
          state_d  = IDLE;
          byte_ok  = rx_s;
          stop_bad = !rx_s;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    word_nx = word_q;
    word_nx[8*byte_idx +: 8] = sh_q;
  end

  assign last      = (byte_idx == IW'(BPW - 1));
  assign idle_part = (state_q == IDLE) && (byte_idx != '0);
  assign full      = word_count[ADDR_WIDTH];

  // word_count never exceeds 2**ADDR_WIDTH, so its low bits
  // serve directly as the write pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bram.bram_we   <= 1'b0;
      bram.bram_addr <= '0;
      bram.bram_din  <= '0;
      word_count     <= '0;
      frame_err      <= 1'b0;
      byte_idx       <= '0;
      word_q         <= '0;
      to_cnt         <= '0;
    end else begin
      bram.bram_we <= 1'b0;
      if (clear) begin
        word_count <= '0;
        frame_err  <= 1'b0;
        byte_idx   <= '0;
        to_cnt     <= '0;
      end else begin
        if (stop_bad) frame_err <= 1'b1;
        if (byte_ok) begin
          word_q   <= word_nx;
          byte_idx <= last ? '0 : byte_idx + 1'b1;
          if (last && !full) begin
            bram.bram_we   <= 1'b1;
            bram.bram_addr <= word_count[ADDR_WIDTH-1:0];
            bram.bram_din  <= word_nx;
            word_count     <= word_count + 1'b1;
          end
        end
        if (idle_part) begin
          if (to_cnt == TW'(TO - 1)) begin
            byte_idx <= '0;
            to_cnt   <= '0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end else begin
          to_cnt <= '0;
        end
      end
    end
  end

endmodule
